// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - state codes, opcode/funct and ALU control constants for the multicycle controller
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/mips_alu_decoder.sv
// rtl/mips_alu_decoder.sv - R-type funct to ALU control map with legality flag
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       legal
);

  // Map the supported R-type functs; anything else is flagged illegal
  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b1;
    case (funct)
      F_ADD:   alu_ctrl = ALU_ADD;
      F_SUB:   alu_ctrl = ALU_SUB;
      F_AND:   alu_ctrl = ALU_AND;
      F_OR:    alu_ctrl = ALU_OR;
      F_SLT:   alu_ctrl = ALU_SLT;
      default: legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multicycle MIPS control FSM with memory handshake and retire counter
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctrl,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             instr_done,
  output logic             illegal_inst,
  output logic [3:0]       state_out,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state;
  state_t           state_next;
  logic [5:0]       op_q;
  logic [5:0]       funct_q;
  logic [CNT_W-1:0] count_q;
  logic [5:0]       dec_funct;
  logic [3:0]       dec_alu_ctrl;
  logic             dec_legal;

  // DECODE judges the live funct; later states only ever see the latched copy
  assign dec_funct = (state == S_DECODE) ? funct : funct_q;

  mips_alu_decoder u_alu_decoder (
    .funct    (dec_funct),
    .alu_ctrl (dec_alu_ctrl),
    .legal    (dec_legal)
  );

  // State, latched instruction fields and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
      count_q <= '0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) begin
        op_q    <= opcode;
        funct_q <= funct;
      end
      if (instr_done) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign state_out   = reset ? 4'd0 : state;
  assign instr_count = reset ? '0 : count_q;

  // Moore output decode and next-state; everything held at zero during reset
  always_comb begin
    state_next    = state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_ctrl      = 4'b0000;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    illegal_inst  = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_ctrl  = ALU_ADD;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          alu_ctrl  = ALU_ADD;
          case (opcode)
            OP_LW, OP_SW: state_next = S_MEM_ADDR;
            OP_RTYPE:     state_next = dec_legal ? S_R_EXEC : S_ILLEGAL;
            OP_BEQ:       state_next = S_BRANCH;
            OP_J:         state_next = S_JUMP;
            OP_ADDI:      state_next = S_ADDI_EXEC;
            default:      state_next = S_ILLEGAL;
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          alu_ctrl   = ALU_ADD;
          state_next = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) state_next = S_MEM_WB;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_next = S_FETCH;
          end
        end
        S_R_EXEC: begin
          alu_src_a  = 1'b1;
          alu_ctrl   = dec_alu_ctrl;
          state_next = S_R_WB;
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_ctrl      = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          instr_done    = 1'b1;
          state_next    = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
        S_ADDI_EXEC: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          alu_ctrl   = ALU_ADD;
          state_next = S_ADDI_WB;
        end
        S_ADDI_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
        S_ILLEGAL: begin
          illegal_inst = 1'b1;
          state_next   = S_FETCH;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Multi-cycle control FSM that sequences the MIPS datapath around the instruction field splitter. It consumes the opcode and funct fields, drives every datapath enable and mux select, and handshakes with the shared instruction/data memory. It also keeps a retired-instruction counter for debug.

Parameters:
CNT_W, 32, width of retired-instruction counter instr_count.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising clk edge
opcode  input  6  inst[31:26] from splitter (IR output)
funct  input  6  inst[5:0] from splitter, meaningful for opcode 000000
mem_ready  input  1  memory handshake: current read/write completes this cycle
mem_read  output  1  memory read request
mem_write  output  1  memory write request
i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
ir_write  output  1  load IR (and PC+4 path) from memory data
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (beq)
pc_source  output  2  00=ALU result, 01=ALUOut (branch target), 10=jump target
alu_src_a  output  1  0=PC, 1=register A
alu_src_b  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_ctrl  output  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
reg_dst  output  1  0=rt, 1=rd
mem_to_reg  output  1  0=ALUOut, 1=MDR
reg_write  output  1  register file write enable
instr_done  output  1  one-cycle pulse when an instruction retires
illegal_inst  output  1  one-cycle pulse on unsupported opcode/funct
state_out  output  4  current state code (debug)
instr_count  output  CNT_W  retired-instruction count

Behaviour:
- Supported: R-type (opcode 000000; funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt), lw 100011, sw 101011, beq 000100, j 000010, addi 001000. Everything else is illegal.
- State codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, ILLEGAL=12.
- Outputs are Moore decodes of the state register. Write strobes in memory states are additionally qualified by mem_ready. Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_source=00. ir_write and pc_write are asserted only in the cycle mem_ready=1. Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=add (branch target precompute). Latch opcode/funct into internal registers; later states use only the latched copies. Next state: lw/sw→MEM_ADDR, R-type with legal funct→R_EXEC, beq→BRANCH, j→JUMP, addi→ADDI_EXEC, otherwise ILLEGAL.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_ctrl=add. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Retire.
- MEM_WR: mem_write=1, i_or_d=1. Retire in the cycle mem_ready=1; otherwise hold.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from latched funct. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Retire.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=sub, pc_write_cond=1, pc_source=01. Retire.
- JUMP: pc_write=1, pc_source=10. Retire.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_ctrl=add. Next state ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Retire.
- ILLEGAL: illegal_inst=1 for one cycle, then FETCH. Not counted; instr_done stays 0.
- Retire means: instr_done=1 that cycle, instr_count increments by 1 at the clock edge (wraps modulo 2^CNT_W), next state FETCH.
- Cycle counts with mem_ready held high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- While mem_ready=0 in FETCH, MEM_RD or MEM_WR: all outputs hold steady and ir_write, pc_write and instr_done stay 0.
- Reset: a clock edge with reset=1 forces state to FETCH, instr_count to 0 and the latched opcode/funct to 0. This applies in any state, including mid-memory-wait; the pending access is abandoned.
- While reset=1, all outputs are forced to 0, state_out reads 0 and instr_count reads 0. Reset takes priority over mem_ready.
- mem_ready outside the memory states is ignored.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum (4-bit codes above)
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - funct constants: F_ADD, F_SUB, F_AND, F_OR, F_SLT
  - alu_ctrl constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
- One sub-module, mips_alu_decoder: a combinational funct→alu_ctrl map with a legal flag. DECODE uses the legal flag; R_EXEC uses alu_ctrl.

Test Plan:
- lw (opcode 100011), mem_ready held 1 → states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_done pulses once; instr_count 0→1.
- add (000000/100000) then sub (000000/100010) → alu_ctrl 0010 then 0110 in R_EXEC; reg_dst=1 in R_WB; 8 cycles total; instr_count=2.
- FETCH with mem_ready low for 3 cycles → mem_read=1 for 4 cycles; ir_write and pc_write high only in the 4th cycle.
- sw with mem_ready low 2 cycles in MEM_WR → mem_write=1 and i_or_d=1 for 3 cycles; retire on the 3rd cycle; reg_write never asserted.
- opcode 111111, then R-type funct 000000 → each goes to ILLEGAL with a single illegal_inst pulse and returns to FETCH; instr_count unchanged.
- reset asserted during MEM_RD, and separately CNT_W=2 with 5 beq → after reset state_out=0, instr_count=0, all outputs 0; beq count wraps 3→0 then reads 1.
